// File: rtl/uart_buffered.sv
// uart_buffered: FIFO-buffered full-duplex 8N1 UART on the 64-bit Wishbone bus.
// Holds the TX/RX byte FIFOs, the register file, and the TX and RX state machines.
// Everything runs in the CPU clock domain.

module uart_buffered_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_push,
    input  logic [7:0]  i_data,
    input  logic        i_pop,
    output logic [7:0]  o_data,
    output logic        o_empty,
    output logic        o_full,
    output logic [AW:0] o_count
);
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    // The extra pointer bit tells full apart from empty when the index bits match.
    assign o_empty = (wptr == rptr);
    assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign o_count = wptr - rptr;
    assign o_data  = mem[rptr[AW-1:0]];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Storage array, written only when a push is accepted.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= i_data;
        end
    end

    // Read and write pointers, which wrap modulo twice the depth.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end
endmodule

module uart_buffered #(
    parameter logic [63:0] MAPPED_ADDRESS = 64'h100000000,
    parameter int          FIFO_DEPTH     = 16,
    parameter logic [15:0] DEFAULT_DIV    = 16'd26
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [63:0] i_wb_adr,
    input  logic [63:0] i_wb_dat,
    inout  wire  [63:0] o_wb_dat,
    input  logic        i_wb_we,
    input  logic [7:0]  i_wb_sel,
    input  logic        i_wb_stb,
    input  logic        i_wb_cyc,
    inout  wire         o_wb_ack,
    inout  wire         o_wb_stall,
    input  logic        i_uart_rx,
    output logic        o_uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Bus decode
    logic        addr_match;
    logic        wb_access;
    logic        wb_write;
    logic        wb_read;
    logic [1:0]  reg_idx;
    logic        div_wr;
    logic        status_wr;
    logic        wb_ack;
    logic [63:0] rd_latch;
    logic [63:0] rd_value;
    logic [63:0] rd_masked;
    logic        unused_wb_dat;

    // Registers
    logic [15:0] divisor;
    logic [2:0]  ctrl;
    logic        overrun;
    logic        frame_err;
    logic        tx_en;
    logic        rx_en;
    logic        loopback;

    // FIFOs
    logic        txf_push;
    logic        txf_pop;
    logic [7:0]  txf_data;
    logic        txf_empty;
    logic        txf_full;
    logic [AW:0] txf_count;
    logic        rxf_push;
    logic        rxf_pop;
    logic [7:0]  rxf_data;
    logic        rxf_empty;
    logic        rxf_full;
    logic [AW:0] rxf_count;

    // Transmitter
    tx_state_t   tx_state;
    tx_state_t   tx_state_n;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_shift_n;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_n;
    logic [3:0]  tx_tick;
    logic [3:0]  tx_tick_n;
    logic [15:0] tx_div;
    logic [15:0] tx_div_n;
    logic        tx_out;
    logic        tx_out_n;
    logic        tx_bit_end;

    // Receiver
    rx_state_t   rx_state;
    rx_state_t   rx_state_n;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_shift_n;
    logic [2:0]  rx_bit;
    logic [2:0]  rx_bit_n;
    logic [3:0]  rx_tick;
    logic [3:0]  rx_tick_n;
    logic [15:0] rx_div;
    logic [15:0] rx_div_n;
    logic        rx_tick_evt;
    logic        rx_line;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic        rx_set_overrun;
    logic        rx_set_frame;

    assign addr_match = (i_wb_adr >= MAPPED_ADDRESS) && (i_wb_adr < MAPPED_ADDRESS + 64'd32);
    assign wb_access  = addr_match && i_wb_cyc && i_wb_stb;
    assign wb_write   = wb_access && i_wb_we;
    assign wb_read    = wb_access && !i_wb_we;
    assign reg_idx    = i_wb_adr[4:3];
    assign div_wr     = wb_write && (reg_idx == 2'd2);
    assign status_wr  = wb_write && (reg_idx == 2'd1);
    assign txf_push   = wb_write && (reg_idx == 2'd0);
    assign rxf_pop    = wb_read && (reg_idx == 2'd0) && !rxf_empty;

    // The bus only carries an 8-bit payload and a 16-bit divisor upward.
    assign unused_wb_dat = &{1'b0, i_wb_dat[63:16]};

    assign tx_en    = ctrl[0];
    assign rx_en    = ctrl[1];
    assign loopback = ctrl[2];

    // The bus outputs are shared, so they are released whenever another slave is addressed.
    assign o_wb_dat   = addr_match ? rd_latch : {64{1'bz}};
    assign o_wb_ack   = addr_match ? wb_ack : 1'bz;
    assign o_wb_stall = wb_access ? 1'b0 : 1'bz;
    assign o_uart_tx  = tx_out;

    uart_buffered_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_txf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (txf_push),
        .i_data  (i_wb_dat[7:0]),
        .i_pop   (txf_pop),
        .o_data  (txf_data),
        .o_empty (txf_empty),
        .o_full  (txf_full),
        .o_count (txf_count)
    );

    uart_buffered_fifo #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rxf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (rxf_push),
        .i_data  (rx_shift),
        .i_pop   (rxf_pop),
        .o_data  (rxf_data),
        .o_empty (rxf_empty),
        .o_full  (rxf_full),
        .o_count (rxf_count)
    );

    // Build the register read value, then zero any byte lanes that are not selected.
    always_comb begin
        rd_value  = '0;
        rd_masked = '0;
        case (reg_idx)
            2'd0: rd_value = rxf_empty ? 64'd0 : {55'd0, 1'b1, rxf_data};
            2'd1: rd_value = {32'd0, 8'(rxf_count), 8'(txf_count), 9'd0,
                              (tx_state != TX_IDLE), frame_err, overrun,
                              rxf_full, !rxf_empty, txf_full, txf_empty};
            2'd2: rd_value = {48'd0, divisor};
            default: rd_value = {61'd0, ctrl};
        endcase
        for (int i = 0; i < 8; i++) begin
            rd_masked[i*8 +: 8] = i_wb_sel[i] ? rd_value[i*8 +: 8] : 8'h00;
        end
    end

    // Acknowledge one cycle after each strobe and capture read data on the strobe edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb_ack   <= 1'b0;
            rd_latch <= '0;
        end else begin
            wb_ack <= wb_access;
            if (wb_read) begin
                rd_latch <= rd_masked;
            end
        end
    end

    // Divisor and control registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            divisor <= DEFAULT_DIV;
            ctrl    <= 3'b011;
        end else begin
            if (div_wr) begin
                divisor <= i_wb_dat[15:0];
            end
            if (wb_write && (reg_idx == 2'd3)) begin
                ctrl <= i_wb_dat[2:0];
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as a software clear wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_set_overrun) begin
                overrun <= 1'b1;
            end else if (status_wr && i_wb_dat[4]) begin
                overrun <= 1'b0;
            end
            if (rx_set_frame) begin
                frame_err <= 1'b1;
            end else if (status_wr && i_wb_dat[5]) begin
                frame_err <= 1'b0;
            end
        end
    end

    // Transmitter state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_tick  <= '0;
            tx_div   <= '0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_shift <= tx_shift_n;
            tx_bit   <= tx_bit_n;
            tx_tick  <= tx_tick_n;
            tx_div   <= tx_div_n;
            tx_out   <= tx_out_n;
        end
    end

    // Transmitter next state: the divider restarts at each frame so every bit is exactly 16 ticks.
    always_comb begin
        tx_state_n = tx_state;
        tx_shift_n = tx_shift;
        tx_bit_n   = tx_bit;
        tx_tick_n  = tx_tick;
        tx_div_n   = tx_div;
        tx_out_n   = tx_out;
        txf_pop    = 1'b0;
        tx_bit_end = 1'b0;
        if (tx_state != TX_IDLE) begin
            if (tx_div == divisor) begin
                tx_div_n   = '0;
                tx_tick_n  = tx_tick + 4'd1;
                tx_bit_end = (tx_tick == 4'd15);
            end else begin
                tx_div_n = tx_div + 16'd1;
            end
        end
        case (tx_state)
            TX_IDLE: begin
                tx_out_n = 1'b1;
                if (tx_en && !txf_empty) begin
                    txf_pop    = 1'b1;
                    tx_shift_n = txf_data;
                    tx_out_n   = 1'b0;
                    tx_div_n   = '0;
                    tx_tick_n  = '0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_DATA;
                    tx_bit_n   = '0;
                    tx_out_n   = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_n = TX_STOP;
                        tx_out_n   = 1'b1;
                    end else begin
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_out_n   = tx_shift[1];
                        tx_bit_n   = tx_bit + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_en && !txf_empty) begin
                        txf_pop    = 1'b1;
                        tx_shift_n = txf_data;
                        tx_out_n   = 1'b0;
                        tx_div_n   = '0;
                        tx_tick_n  = '0;
                        tx_state_n = TX_START;
                    end else begin
                        tx_out_n   = 1'b1;
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (div_wr) begin
            tx_div_n = '0;
        end
    end

    // Two-flop synchronizer on the serial input, plus one more flop for edge detection.
    assign rx_line = loopback ? tx_out : i_uart_rx;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_tick  <= '0;
            rx_div   <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_shift <= rx_shift_n;
            rx_bit   <= rx_bit_n;
            rx_tick  <= rx_tick_n;
            rx_div   <= rx_div_n;
        end
    end

    // Receiver next state: tick 8 validates the start bit, after which every 16th tick is mid-bit.
    always_comb begin
        rx_state_n     = rx_state;
        rx_shift_n     = rx_shift;
        rx_bit_n       = rx_bit;
        rx_tick_n      = rx_tick;
        rx_div_n       = rx_div;
        rx_tick_evt    = 1'b0;
        rxf_push       = 1'b0;
        rx_set_overrun = 1'b0;
        rx_set_frame   = 1'b0;
        if (rx_state != RX_IDLE) begin
            if (rx_div == divisor) begin
                rx_div_n    = '0;
                rx_tick_n   = rx_tick + 4'd1;
                rx_tick_evt = 1'b1;
            end else begin
                rx_div_n = rx_div + 16'd1;
            end
        end
        case (rx_state)
            RX_IDLE: begin
                if (rx_en && rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_div_n   = '0;
                    rx_tick_n  = '0;
                end
            end
            RX_START: begin
                if (rx_tick_evt && (rx_tick == 4'd7)) begin
                    rx_tick_n = '0;
                    if (!rx_sync) begin
                        rx_state_n = RX_DATA;
                        rx_bit_n   = '0;
                    end else begin
                        rx_state_n = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick_evt && (rx_tick == 4'd15)) begin
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (rx_tick_evt && (rx_tick == 4'd15)) begin
                    rx_state_n = RX_IDLE;
                    if (rx_sync) begin
                        if (rxf_full) begin
                            rx_set_overrun = 1'b1;
                        end else begin
                            rxf_push = 1'b1;
                        end
                    end else begin
                        rx_set_frame = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (div_wr) begin
            rx_div_n = '0;
        end
    end
endmodule
